id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the instruction-fetch stage.
- Consumes the fetched instruction and PC+4, and decodes the MIPS opcode into control signals.
- Reads two operands from a 32x32 register file, sign-extends the immediate, and registers everything into the ID/EX pipeline register.
- Also owns the register-file write port driven by the writeback stage.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 32, register-file depth; register 0 is hardwired to zero.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_instruction  input  32  instruction from the fetch stage.
- in_pc_plus_four  input  32  PC+4 from the fetch stage.
- in_bubble  input  1  when 1, the next ID/EX entry is a NOP (stall or flush).
- in_wb_reg_write  input  1  writeback write enable.
- in_wb_write_reg  input  5  writeback destination register.
- in_wb_write_data  input  32  writeback data.
- read_data1_out  output  32  registered rs operand.
- read_data2_out  output  32  registered rt operand.
- imm_ext_out  output  32  registered sign-extended instruction[15:0].
- rt_out  output  5  registered instruction[20:16].
- rd_out  output  5  registered instruction[15:11].
- pc_plus_four_out  output  32  registered PC+4.
- reg_dst_out, alu_src_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, branch_out  output  1 each  registered control signals.
- alu_op_out  output  2  registered ALU-op class.

Behaviour:
- Reset (rst=1 at a posedge):
  - All outputs go to 0.
  - All 32 registers are cleared to 0.
  - A writeback request in the same cycle is discarded.
- Latency: exactly one cycle. Inputs sampled at posedge N appear on the outputs after posedge N.
- Decode on opcode = in_instruction[31:26]:
  - 0x00 (R-type): reg_dst=1, reg_write=1, alu_op=10.
  - 0x23 (lw): alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - 0x2B (sw): alu_src=1, mem_write=1, alu_op=00.
  - 0x04 (beq): branch=1, alu_op=01.
  - 0x08 (addi): alu_src=1, reg_write=1, alu_op=00.
  - Any other opcode: all controls 0 (NOP). It is not an error.
  - Any control not listed for an opcode is 0.
- Register read:
  - rs = instruction[25:21], rt = instruction[20:16].
  - Reads are combinational from the array and captured into the ID/EX register.
  - Reading register 0 always yields 0.
- Register write:
  - On posedge when in_wb_reg_write=1 and in_wb_write_reg!=0, the array is updated.
  - Writes to register 0 are ignored.
- Sign extension: imm_ext_out = {16{instr[15]}, instr[15:0]}.
- in_bubble=1:
  - All eight control outputs are registered as 0.
  - Data outputs still capture their normal decoded values.
  - The register-file write proceeds normally.
- Simultaneous write and read of the same nonzero register in one cycle: behaviour depends on WB_BYPASS_EN (below).
- X or unknown on in_instruction is decoded as NOP: controls forced to 0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - If in_wb_reg_write=1, in_wb_write_reg!=0, and in_wb_write_reg equals rs (or rt), the corresponding read_data output captures in_wb_write_data in that same cycle (write-through).
  - Rule: a write committed at posedge N appears in read_data at posedge N.
- Undefined: the read captures the old array value. The new value is visible from the next cycle.

Test Plan:
- Reset: assert rst for 2 cycles, having preloaded register 5 = 0x1234 before reset → all outputs 0; a subsequent read of register 5 returns 0.
- R-type: write reg8=7 and reg9=3, then instruction 0x01095020 (add $10,$8,$9) → read_data1=7, read_data2=3, rd=10, reg_dst=1, reg_write=1, alu_op=10, all other controls 0.
- lw sign extension: instruction 0x8D09FFFC (lw $9,-4($8)) → imm_ext=0xFFFFFFFC, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, rt=9.
- Register 0: WB writes reg0=0xDEAD, then instruction add $1,$0,$0 → read_data1=read_data2=0.
- Bubble: instruction sw 0xAD090004 with in_bubble=1 → all controls 0; imm_ext=4; pc_plus_four passes through.
- Same-cycle hazard: WB writes reg8=0x55 while decoding an instruction with rs=8 and reg8 previously 0x11 → read_data1=0x55 with WB_BYPASS_EN, 0x11 without it.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode stage: opcode decode, 32x32 register file, sign-extend, ID/EX register.
// Latency: one cycle, inputs sampled at posedge N are visible on the outputs after posedge N.
// Backpressure: none; in_bubble turns the next ID/EX entry into a NOP (controls 0, data kept).
// Optional macro WB_BYPASS_EN: same-cycle writeback data is forwarded into the operand reads.
module id_stage #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       in_instruction,
   input  logic [DATA_W-1:0] in_pc_plus_four,
   input  logic              in_bubble,
   input  logic              in_wb_reg_write,
   input  logic [4:0]        in_wb_write_reg,
   input  logic [DATA_W-1:0] in_wb_write_data,
   output logic [DATA_W-1:0] read_data1_out,
   output logic [DATA_W-1:0] read_data2_out,
   output logic [DATA_W-1:0] imm_ext_out,
   output logic [4:0]        rt_out,
   output logic [4:0]        rd_out,
   output logic [DATA_W-1:0] pc_plus_four_out,
   output logic              reg_dst_out,
   output logic              alu_src_out,
   output logic              mem_to_reg_out,
   output logic              reg_write_out,
   output logic              mem_read_out,
   output logic              mem_write_out,
   output logic              branch_out,
   output logic [1:0]        alu_op_out
);

   // Control bundle carried through the ID/EX register.
   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   // Instruction fields.
   logic [5:0]  opcode;
   logic [4:0]  rs_idx;
   logic [4:0]  rt_idx;
   logic [4:0]  rd_idx;
   logic [15:0] imm16;

   assign opcode = in_instruction[31:26];
   assign rs_idx = in_instruction[25:21];
   assign rt_idx = in_instruction[20:16];
   assign rd_idx = in_instruction[15:11];
   assign imm16  = in_instruction[15:0];

   // Register file storage; entry 0 is never written and is masked on read.
   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic              wb_en;

   assign wb_en = in_wb_reg_write && (in_wb_write_reg != 5'd0);

   // Writeback port: reset clears every entry and drops a concurrent write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_en) begin
         rf_q[in_wb_write_reg] <= in_wb_write_data;
      end
   end

   // Operand reads; the array value is the pre-write value for this edge.
   logic [DATA_W-1:0] rd1_d;
   logic [DATA_W-1:0] rd2_d;

   // Combinational register reads with zero-register masking and optional write-through.
   always_comb begin
      rd1_d = (rs_idx == 5'd0) ? '0 : rf_q[rs_idx];
      rd2_d = (rt_idx == 5'd0) ? '0 : rf_q[rt_idx];
`ifdef WB_BYPASS_EN
      // wb_en already excludes register 0, so the zero mask stays intact.
      if (wb_en && (in_wb_write_reg == rs_idx)) begin
         rd1_d = in_wb_write_data;
      end
      if (wb_en && (in_wb_write_reg == rt_idx)) begin
         rd2_d = in_wb_write_data;
      end
`endif
   end

   // Opcode decode; unlisted opcodes fall to the default NOP. An opcode with
   // unknown bits matches no case item, so it also lands on the NOP default.
   ctrl_t ctrl_dec;

   always_comb begin
      ctrl_dec = '0;
      case (opcode)
         OP_RTYPE: begin
            ctrl_dec.reg_dst   = 1'b1;
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_op    = ALUOP_RTYPE;
         end
         OP_LW: begin
            ctrl_dec.alu_src    = 1'b1;
            ctrl_dec.mem_to_reg = 1'b1;
            ctrl_dec.reg_write  = 1'b1;
            ctrl_dec.mem_read   = 1'b1;
            ctrl_dec.alu_op     = ALUOP_MEM;
         end
         OP_SW: begin
            ctrl_dec.alu_src   = 1'b1;
            ctrl_dec.mem_write = 1'b1;
            ctrl_dec.alu_op    = ALUOP_MEM;
         end
         OP_BEQ: begin
            ctrl_dec.branch = 1'b1;
            ctrl_dec.alu_op = ALUOP_BRANCH;
         end
         OP_ADDI: begin
            ctrl_dec.alu_src   = 1'b1;
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_op    = ALUOP_MEM;
         end
         default: begin
            ctrl_dec = '0;
         end
      endcase
   end

   // Next-state values for the ID/EX register.
   ctrl_t             ctrl_d;
   logic [DATA_W-1:0] imm_d;

   // A bubble squashes only the controls; data fields keep their decoded values.
   always_comb begin
      ctrl_d = in_bubble ? ctrl_t'('0) : ctrl_dec;
      imm_d  = {{(DATA_W-16){imm16[15]}}, imm16};
   end

   // ID/EX pipeline register.
   ctrl_t             ctrl_q;
   logic [DATA_W-1:0] rd1_q;
   logic [DATA_W-1:0] rd2_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] pc4_q;
   logic [4:0]        rt_q;
   logic [4:0]        rd_q;

   // Capture decoded controls and operands every cycle; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         imm_q  <= '0;
         pc4_q  <= '0;
         rt_q   <= '0;
         rd_q   <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         rd1_q  <= rd1_d;
         rd2_q  <= rd2_d;
         imm_q  <= imm_d;
         pc4_q  <= in_pc_plus_four;
         rt_q   <= rt_idx;
         rd_q   <= rd_idx;
      end
   end

   assign read_data1_out   = rd1_q;
   assign read_data2_out   = rd2_q;
   assign imm_ext_out      = imm_q;
   assign pc_plus_four_out = pc4_q;
   assign rt_out           = rt_q;
   assign rd_out           = rd_q;
   assign reg_dst_out      = ctrl_q.reg_dst;
   assign alu_src_out      = ctrl_q.alu_src;
   assign mem_to_reg_out   = ctrl_q.mem_to_reg;
   assign reg_write_out    = ctrl_q.reg_write;
   assign mem_read_out     = ctrl_q.mem_read;
   assign mem_write_out    = ctrl_q.mem_write;
   assign branch_out       = ctrl_q.branch;
   assign alu_op_out       = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: vector table for decode, plus reset, register-0,
// bubble-with-writeback and same-cycle writeback/read sequences.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_instruction;
   logic [31:0] in_pc_plus_four;
   logic        in_bubble;
   logic        in_wb_reg_write;
   logic [4:0]  in_wb_write_reg;
   logic [31:0] in_wb_write_data;
   logic [31:0] read_data1_out;
   logic [31:0] read_data2_out;
   logic [31:0] imm_ext_out;
   logic [4:0]  rt_out;
   logic [4:0]  rd_out;
   logic [31:0] pc_plus_four_out;
   logic        reg_dst_out, alu_src_out, mem_to_reg_out, reg_write_out;
   logic        mem_read_out, mem_write_out, branch_out;
   logic [1:0]  alu_op_out;

   int n_cmp = 0;
   int n_bad = 0;

   id_stage #(.DATA_W(32), .NUM_REGS(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_instruction   (in_instruction),
      .in_pc_plus_four  (in_pc_plus_four),
      .in_bubble        (in_bubble),
      .in_wb_reg_write  (in_wb_reg_write),
      .in_wb_write_reg  (in_wb_write_reg),
      .in_wb_write_data (in_wb_write_data),
      .read_data1_out   (read_data1_out),
      .read_data2_out   (read_data2_out),
      .imm_ext_out      (imm_ext_out),
      .rt_out           (rt_out),
      .rd_out           (rd_out),
      .pc_plus_four_out (pc_plus_four_out),
      .reg_dst_out      (reg_dst_out),
      .alu_src_out      (alu_src_out),
      .mem_to_reg_out   (mem_to_reg_out),
      .reg_write_out    (reg_write_out),
      .mem_read_out     (mem_read_out),
      .mem_write_out    (mem_write_out),
      .branch_out       (branch_out),
      .alu_op_out       (alu_op_out)
   );

   always #5 clk = ~clk;

   // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
   logic [8:0] ctrl_o;
   assign ctrl_o = {reg_dst_out, alu_src_out, mem_to_reg_out, reg_write_out,
                    mem_read_out, mem_write_out, branch_out, alu_op_out};

   localparam logic [8:0] C_R    = 9'b1_0_0_1_0_0_0_10;
   localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
   localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
   localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
   localparam logic [8:0] C_ADDI = 9'b0_1_0_1_0_0_0_00;
   localparam logic [8:0] C_NOP  = 9'b0;

   typedef struct {
      logic [31:0] instr;
      logic        bubble;
      logic [8:0]  ctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs and let the rising edge sample them.
   task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input logic bub,
                        input logic we, input logic [4:0] wreg, input logic [31:0] wdat);
      in_instruction   = instr;
      in_pc_plus_four  = pc;
      in_bubble        = bub;
      in_wb_reg_write  = we;
      in_wb_write_reg  = wreg;
      in_wb_write_data = wdat;
      tick();
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
      apply(32'h0, 32'h0, 1'b0, 1'b1, r, d);
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".rd1"}, read_data1_out, 32'h0);
      check({name, ".rd2"}, read_data2_out, 32'h0);
      check({name, ".imm"}, imm_ext_out, 32'h0);
      check({name, ".pc4"}, pc_plus_four_out, 32'h0);
      check({name, ".rt_rd"}, {22'h0, rt_out, rd_out}, 32'h0);
      check({name, ".ctrl"}, {23'h0, ctrl_o}, 32'h0);
   endtask

   initial begin
      // instr, bubble, ctrl, rd1, rd2, imm, rt, rd   (reg8=7, reg9=3, reg0 write attempted)
      vecs[0] = '{32'h01095020, 1'b0, C_R,    32'd7, 32'd3, 32'h00005020, 5'd9,  5'd10};
      vecs[1] = '{32'h8D09FFFC, 1'b0, C_LW,   32'd7, 32'd3, 32'hFFFFFFFC, 5'd9,  5'd31};
      vecs[2] = '{32'hAD090004, 1'b0, C_SW,   32'd7, 32'd3, 32'h00000004, 5'd9,  5'd0};
      vecs[3] = '{32'hAD090004, 1'b1, C_NOP,  32'd7, 32'd3, 32'h00000004, 5'd9,  5'd0};
      vecs[4] = '{32'h11090008, 1'b0, C_BEQ,  32'd7, 32'd3, 32'h00000008, 5'd9,  5'd0};
      vecs[5] = '{32'h21288000, 1'b0, C_ADDI, 32'd3, 32'd7, 32'hFFFF8000, 5'd8,  5'd16};
      vecs[6] = '{32'hFD090001, 1'b0, C_NOP,  32'd7, 32'd3, 32'h00000001, 5'd9,  5'd0};
      vecs[7] = '{32'h00000820, 1'b0, C_R,    32'd0, 32'd0, 32'h00000820, 5'd0,  5'd1};
      vecs[8] = '{32'h08000000, 1'b0, C_NOP,  32'd0, 32'd0, 32'h00000000, 5'd0,  5'd0};
      vecs[9] = '{32'h01095020, 1'b1, C_NOP,  32'd7, 32'd3, 32'h00005020, 5'd9,  5'd10};

      // Reset with a live instruction present: outputs must stay zero.
      rst = 1'b1;
      apply(32'h8D09FFFC, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'h0);
      check_all_zero("reset1");
      apply(32'h8D09FFFC, 32'h1234_5678, 1'b0, 1'b0, 5'd0, 32'h0);
      check_all_zero("reset2");
      rst = 1'b0;

      // Preload reg5 and confirm it is really there before the second reset.
      wb_write(5'd5, 32'h1234);
      apply(32'h00A00000, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
      check("preload.reg5", read_data1_out, 32'h1234);

      // Second reset for two cycles with a concurrent writeback that must be dropped.
      rst = 1'b1;
      apply(32'h01095020, 32'h8, 1'b0, 1'b1, 5'd7, 32'h77);
      check_all_zero("reset3");
      apply(32'h01095020, 32'h8, 1'b0, 1'b1, 5'd7, 32'h77);
      check_all_zero("reset4");
      rst = 1'b0;
      apply(32'h00A70000, 32'hC, 1'b0, 1'b0, 5'd0, 32'h0);
      check("postreset.reg5", read_data1_out, 32'h0);
      check("postreset.reg7", read_data2_out, 32'h0);

      // Operand setup, including an attempted write to register 0.
      wb_write(5'd8, 32'd7);
      wb_write(5'd9, 32'd3);
      wb_write(5'd0, 32'hDEAD);

      for (int i = 0; i < NV; i++) begin
         logic [31:0] pc;
         pc = 32'h1000 + 32'(i * 4);
         apply(vecs[i].instr, pc, vecs[i].bubble, 1'b0, 5'd0, 32'h0);
         check($sformatf("v%0d.ctrl", i), {23'h0, ctrl_o}, {23'h0, vecs[i].ctrl});
         check($sformatf("v%0d.rd1", i), read_data1_out, vecs[i].rd1);
         check($sformatf("v%0d.rd2", i), read_data2_out, vecs[i].rd2);
         check($sformatf("v%0d.imm", i), imm_ext_out, vecs[i].imm);
         check($sformatf("v%0d.rt", i), {27'h0, rt_out}, {27'h0, vecs[i].rt});
         check($sformatf("v%0d.rd", i), {27'h0, rd_out}, {27'h0, vecs[i].rd});
         check($sformatf("v%0d.pc4", i), pc_plus_four_out, pc);
      end

      // Bubble cycle still commits its writeback.
      apply(32'hAD090004, 32'h2000, 1'b1, 1'b1, 5'd12, 32'hABC);
      check("bubwb.ctrl", {23'h0, ctrl_o}, 32'h0);
      check("bubwb.pc4", pc_plus_four_out, 32'h2000);
      apply(32'h01800000, 32'h2004, 1'b0, 1'b0, 5'd0, 32'h0);
      check("bubwb.reg12", read_data1_out, 32'hABC);

      // Same-cycle hazard on rs: reg8 holds 0x11, writeback of 0x55 in the decode cycle.
      wb_write(5'd8, 32'h11);
      apply(32'h01095020, 32'h3000, 1'b0, 1'b1, 5'd8, 32'h55);
`ifdef WB_BYPASS_EN
      check("hazard.rs", read_data1_out, 32'h55);
`else
      check("hazard.rs", read_data1_out, 32'h11);
`endif
      check("hazard.rs_other", read_data2_out, 32'd3);
      apply(32'h01095020, 32'h3004, 1'b0, 1'b0, 5'd0, 32'h0);
      check("hazard.rs_next", read_data1_out, 32'h55);

      // Same-cycle hazard on rt.
      apply(32'h01095020, 32'h3008, 1'b0, 1'b1, 5'd9, 32'h99);
`ifdef WB_BYPASS_EN
      check("hazard.rt", read_data2_out, 32'h99);
`else
      check("hazard.rt", read_data2_out, 32'd3);
`endif
      apply(32'h01095020, 32'h300C, 1'b0, 1'b0, 5'd0, 32'h0);
      check("hazard.rt_next", read_data2_out, 32'h99);

      // Writeback to register 0 in the same cycle as a read of register 0.
      apply(32'h00000820, 32'h3010, 1'b0, 1'b1, 5'd0, 32'hBEEF);
      check("hazard.r0_rs", read_data1_out, 32'h0);
      check("hazard.r0_rt", read_data2_out, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
